// File: rtl/recv_payload_reader_pkg.sv
// recv_payload_reader_pkg
// Shared definitions for the receive payload reader: the flow ID and
// payload-entry widths, and the reader FSM state encoding.
package recv_payload_reader_pkg;

    localparam int FLOW_ID_W            = 8;
    localparam int PAYLOAD_ENTRY_ADDR_W = 16;
    localparam int PAYLOAD_ENTRY_LEN_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QWAIT    = 3'd1,
        ST_MEM_REQ  = 3'd2,
        ST_MEM_DATA = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

endpackage

// File: rtl/recv_payload_reader.sv
// recv_payload_reader
// Application-side consumer of the receive per-flow payload queues. Takes
// one read request at a time, dequeues one entry from the payload queues,
// streams the entry's payload from payload memory in DATA_W-wide beats and
// closes the request with a completion (flow ID, length, empty flag).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   app_req_*                 application read request (val/rdy, flowid)
//   read_payload_req_*        dequeue request to the payload queues (no rdy)
//   read_payload_resp_*       queue response, QUEUE_LAT cycles after request
//   mem_rd_req_*              payload memory read request (val/rdy, addr)
//   mem_rd_resp_*             payload memory read data (val/rdy, data)
//   app_data_*                payload stream to app (byte 0 in MSBs)
//   app_resp_*                completion to app (flowid, empty, len)
//
// state       | meaning
// ST_IDLE     | ready for a request; dequeue pulse issued on acceptance
// ST_QWAIT    | counting down to the queue response sample point
// ST_MEM_REQ  | issuing the read for the next payload beat
// ST_MEM_DATA | passing the returned beat through to the app
// ST_RESP     | holding the completion until the app takes it
module recv_payload_reader
    import recv_payload_reader_pkg::*;
#(
    parameter int DATA_W    = 256,
    parameter int QUEUE_LAT = 2
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               app_req_val,
    input  logic [FLOW_ID_W-1:0]               app_req_flowid,
    output logic                               app_req_rdy,

    output logic                               read_payload_req_val,
    output logic [FLOW_ID_W-1:0]               read_payload_req_flowid,

    input  logic                               read_payload_resp_val,
    input  logic                               read_payload_resp_empty,
    input  logic [PAYLOAD_ENTRY_ADDR_W-1:0]    read_payload_resp_addr,
    input  logic [PAYLOAD_ENTRY_LEN_W-1:0]     read_payload_resp_len,

    output logic                               mem_rd_req_val,
    input  logic                               mem_rd_req_rdy,
    output logic [PAYLOAD_ENTRY_ADDR_W-1:0]    mem_rd_req_addr,

    input  logic                               mem_rd_resp_val,
    output logic                               mem_rd_resp_rdy,
    input  logic [DATA_W-1:0]                  mem_rd_resp_data,

    output logic                               app_data_val,
    input  logic                               app_data_rdy,
    output logic [DATA_W-1:0]                  app_data,
    output logic                               app_data_last,
    output logic [$clog2(DATA_W/8)-1:0]        app_data_padbytes,

    output logic                               app_resp_val,
    input  logic                               app_resp_rdy,
    output logic [FLOW_ID_W-1:0]               app_resp_flowid,
    output logic                               app_resp_empty,
    output logic [PAYLOAD_ENTRY_LEN_W-1:0]     app_resp_len
);

    localparam int DATA_BYTES = DATA_W / 8;
    localparam int PAD_W      = $clog2(DATA_BYTES);
    localparam int CNT_W      = (QUEUE_LAT > 1) ? $clog2(QUEUE_LAT) : 1;

    localparam logic [CNT_W-1:0]                WAIT_INIT = CNT_W'(QUEUE_LAT - 1);
    localparam logic [PAYLOAD_ENTRY_LEN_W-1:0]  BEAT_LEN  = PAYLOAD_ENTRY_LEN_W'(DATA_BYTES);
    localparam logic [PAYLOAD_ENTRY_ADDR_W-1:0] BEAT_ADDR = PAYLOAD_ENTRY_ADDR_W'(DATA_BYTES);

    state_e                          state;
    state_e                          state_nxt;
    logic [CNT_W-1:0]                wait_cnt;
    logic [FLOW_ID_W-1:0]            flowid_r;
    logic                            empty_r;
    logic [PAYLOAD_ENTRY_LEN_W-1:0]  len_r;
    logic [PAYLOAD_ENTRY_ADDR_W-1:0] cur_addr;
    logic [PAYLOAD_ENTRY_LEN_W-1:0]  remaining;

    logic beat_last;
    logic beat_xfer;
    logic q_empty;

    assign beat_last = (remaining <= BEAT_LEN);
    assign beat_xfer = mem_rd_resp_val && app_data_rdy;
    // A queue that reports empty is treated the same as one that returned no entry.
    assign q_empty   = !read_payload_resp_val || read_payload_resp_empty;

    assign mem_rd_req_addr = cur_addr;
    assign app_data        = mem_rd_resp_data;
    assign app_resp_flowid = flowid_r;
    assign app_resp_empty  = empty_r;
    assign app_resp_len    = len_r;

    always_comb begin
        state_nxt               = state;
        app_req_rdy             = 1'b0;
        read_payload_req_val    = 1'b0;
        read_payload_req_flowid = '0;
        mem_rd_req_val          = 1'b0;
        mem_rd_resp_rdy         = 1'b0;
        app_data_val            = 1'b0;
        app_data_last           = 1'b0;
        app_data_padbytes       = '0;
        app_resp_val            = 1'b0;

        case (state)
            ST_IDLE: begin
                app_req_rdy = 1'b1;
                if (app_req_val) begin
                    read_payload_req_val    = 1'b1;
                    read_payload_req_flowid = app_req_flowid;
                    state_nxt               = ST_QWAIT;
                end
            end
            ST_QWAIT: begin
                if (wait_cnt == '0) begin
                    if (q_empty || (read_payload_resp_len == '0)) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_MEM_REQ;
                    end
                end
            end
            ST_MEM_REQ: begin
                mem_rd_req_val = 1'b1;
                if (mem_rd_req_rdy) begin
                    state_nxt = ST_MEM_DATA;
                end
            end
            ST_MEM_DATA: begin
                mem_rd_resp_rdy = app_data_rdy;
                app_data_val    = mem_rd_resp_val;
                app_data_last   = beat_last;
                // Full final beat truncates to zero padding.
                if (beat_last) begin
                    app_data_padbytes = PAD_W'(BEAT_LEN - remaining);
                end
                if (beat_xfer) begin
                    state_nxt = beat_last ? ST_RESP : ST_MEM_REQ;
                end
            end
            ST_RESP: begin
                app_resp_val = 1'b1;
                if (app_resp_rdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            flowid_r  <= '0;
            empty_r   <= 1'b0;
            len_r     <= '0;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (app_req_val) begin
                        flowid_r <= app_req_flowid;
                        wait_cnt <= WAIT_INIT;
                        empty_r  <= 1'b0;
                        len_r    <= '0;
                    end
                end
                ST_QWAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else if (q_empty) begin
                        empty_r <= 1'b1;
                        len_r   <= '0;
                    end else begin
                        empty_r   <= 1'b0;
                        len_r     <= read_payload_resp_len;
                        cur_addr  <= read_payload_resp_addr;
                        remaining <= read_payload_resp_len;
                    end
                end
                ST_MEM_REQ: begin
                    if (mem_rd_req_rdy) begin
                        cur_addr <= cur_addr + BEAT_ADDR;
                    end
                end
                ST_MEM_DATA: begin
                    if (beat_xfer) begin
                        remaining <= remaining - BEAT_LEN;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
